// File: rtl/cus_tag_cam_config.sv
// Shadow/active configuration store for the custom-tag parser CAM and expected ethertype.
// A commit copies shadow to active only at a packet boundary of the snooped parser stream.
module cus_tag_cam_config #(
  parameter int          AXIS_ID_WIDTH     = 4,
  parameter int          MAX_TAG_SIZE_BITS = 48,
  parameter logic [15:0] RESET_ETYPE       = 16'h0000,
  parameter int          GEN_WIDTH         = 8,
  localparam int         NUM_AXIS_ID       = 2**AXIS_ID_WIDTH
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         cfg_wr_valid,
  output logic                         cfg_wr_ready,
  input  logic [AXIS_ID_WIDTH-1:0]     cfg_wr_id,
  input  logic                         cfg_wr_has_tag,
  input  logic [MAX_TAG_SIZE_BITS-1:0] cfg_wr_tag,
  input  logic [MAX_TAG_SIZE_BITS-1:0] cfg_wr_mask,
  input  logic                         cfg_etype_wr,
  input  logic [15:0]                  cfg_etype_data,
  input  logic                         cfg_commit,
  output logic                         cfg_pending,
  output logic                         cfg_done,
  output logic [GEN_WIDTH-1:0]         cfg_generation,
  input  logic                         mon_tvalid,
  input  logic                         mon_tready,
  input  logic                         mon_tlast,
  output logic [15:0]                  expected_etype,
  output logic                         has_cus_tag      [NUM_AXIS_ID],
  output logic [MAX_TAG_SIZE_BITS-1:0] custom_tags      [NUM_AXIS_ID],
  output logic [MAX_TAG_SIZE_BITS-1:0] custom_tag_masks [NUM_AXIS_ID]
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [0:0]                   state_q, state_d;
  logic                         in_pkt_q, in_pkt_d;
  logic                         done_q;
  logic [GEN_WIDTH-1:0]         gen_q;
  logic                         beat_s, boundary_s, apply_s, wr_en_s, etype_en_s;

  logic                         sh_has_q  [NUM_AXIS_ID];
  logic [MAX_TAG_SIZE_BITS-1:0] sh_tag_q  [NUM_AXIS_ID];
  logic [MAX_TAG_SIZE_BITS-1:0] sh_mask_q [NUM_AXIS_ID];
  logic [15:0]                  sh_etype_q;

  logic                         act_has_q  [NUM_AXIS_ID];
  logic [MAX_TAG_SIZE_BITS-1:0] act_tag_q  [NUM_AXIS_ID];
  logic [MAX_TAG_SIZE_BITS-1:0] act_mask_q [NUM_AXIS_ID];
  logic [15:0]                  act_etype_q;

  // Packet tracking and commit FSM; boundary means the next accepted beat starts a packet.
  always_comb begin
    beat_s = mon_tvalid & mon_tready;
    if (in_pkt_q) begin
      in_pkt_d = ~(beat_s & mon_tlast);
    end else begin
      in_pkt_d = beat_s & ~mon_tlast;
    end
    boundary_s = ~in_pkt_d;
    state_d    = state_q;
    apply_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_commit) begin
          state_d = ST_PENDING;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (boundary_s) begin
          state_d = ST_IDLE;
          apply_s = 1'b1;
        end else begin
          state_d = ST_PENDING;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    wr_en_s    = (state_q == ST_IDLE) & cfg_wr_valid;
    etype_en_s = (state_q == ST_IDLE) & cfg_etype_wr;
  end

  // Control state: FSM, packet tracker, done pulse and generation counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      in_pkt_q <= 1'b0;
      done_q   <= 1'b0;
      gen_q    <= {GEN_WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      in_pkt_q <= in_pkt_d;
      done_q   <= apply_s;
      if (apply_s) begin
        gen_q <= gen_q + GEN_WIDTH'(1);
      end
    end
  end

  // Shadow copy: written by software only while no commit is outstanding.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_AXIS_ID; i++) begin
        sh_has_q[i]  <= 1'b0;
        sh_tag_q[i]  <= {MAX_TAG_SIZE_BITS{1'b0}};
        sh_mask_q[i] <= {MAX_TAG_SIZE_BITS{1'b0}};
      end
      sh_etype_q <= RESET_ETYPE;
    end else begin
      if (wr_en_s) begin
        sh_has_q[cfg_wr_id]  <= cfg_wr_has_tag;
        sh_tag_q[cfg_wr_id]  <= cfg_wr_tag;
        sh_mask_q[cfg_wr_id] <= cfg_wr_mask;
      end
      if (etype_en_s) begin
        sh_etype_q <= cfg_etype_data;
      end
    end
  end

  // Active copy: whole-table atomic update at the apply edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_AXIS_ID; i++) begin
        act_has_q[i]  <= 1'b0;
        act_tag_q[i]  <= {MAX_TAG_SIZE_BITS{1'b0}};
        act_mask_q[i] <= {MAX_TAG_SIZE_BITS{1'b0}};
      end
      act_etype_q <= RESET_ETYPE;
    end else if (apply_s) begin
      for (int i = 0; i < NUM_AXIS_ID; i++) begin
        act_has_q[i]  <= sh_has_q[i];
        act_tag_q[i]  <= sh_tag_q[i];
        act_mask_q[i] <= sh_mask_q[i];
      end
      act_etype_q <= sh_etype_q;
    end
  end

  assign cfg_wr_ready     = (state_q == ST_IDLE);
  assign cfg_pending      = (state_q == ST_PENDING);
  assign cfg_done         = done_q;
  assign cfg_generation   = gen_q;
  assign expected_etype   = act_etype_q;
  assign has_cus_tag      = act_has_q;
  assign custom_tags      = act_tag_q;
  assign custom_tag_masks = act_mask_q;

endmodule

// File: tb/tb_cus_tag_cam_config.sv
// Randomized bench for cus_tag_cam_config: packet-level reference model plus a commit scoreboard
// that a separate monitor drains whenever the DUT pulses cfg_done.
module tb_cus_tag_cam_config;
  localparam int N = 16;
  localparam int T = 48;
  localparam logic [15:0] RST_ET = 16'hABCD;

  typedef struct packed {
    logic [7:0]            gen;
    logic [15:0]           et;
    logic [N-1:0]          has;
    logic [N-1:0][T-1:0]   tag;
    logic [N-1:0][T-1:0]   mask;
  } snap_t;

  logic aclk = 1'b0, aresetn = 1'b0;
  logic cfg_wr_valid = 1'b0, cfg_wr_ready, cfg_wr_has_tag = 1'b0;
  logic [3:0] cfg_wr_id = 4'd0;
  logic [T-1:0] cfg_wr_tag = '0, cfg_wr_mask = '0;
  logic cfg_etype_wr = 1'b0, cfg_commit = 1'b0, cfg_pending, cfg_done;
  logic [15:0] cfg_etype_data = 16'h0000, expected_etype;
  logic [7:0] cfg_generation;
  logic mon_tvalid = 1'b0, mon_tready = 1'b0, mon_tlast = 1'b0;
  logic has_cus_tag [N];
  logic [T-1:0] custom_tags [N];
  logic [T-1:0] custom_tag_masks [N];

  int checks = 0, errors = 0;
  snap_t sb_q [$];
  snap_t m_sh, m_act;
  logic  m_pend, m_in_pkt, m_done;
  int    m_gen;

  cus_tag_cam_config #(.AXIS_ID_WIDTH(4), .MAX_TAG_SIZE_BITS(T), .RESET_ETYPE(RST_ET), .GEN_WIDTH(8)) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_wr_valid(cfg_wr_valid), .cfg_wr_ready(cfg_wr_ready),
    .cfg_wr_id(cfg_wr_id), .cfg_wr_has_tag(cfg_wr_has_tag), .cfg_wr_tag(cfg_wr_tag),
    .cfg_wr_mask(cfg_wr_mask), .cfg_etype_wr(cfg_etype_wr), .cfg_etype_data(cfg_etype_data),
    .cfg_commit(cfg_commit), .cfg_pending(cfg_pending), .cfg_done(cfg_done),
    .cfg_generation(cfg_generation), .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
    .mon_tlast(mon_tlast), .expected_etype(expected_etype), .has_cus_tag(has_cus_tag),
    .custom_tags(custom_tags), .custom_tag_masks(custom_tag_masks));

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sh = '0;
    m_sh.et = RST_ET;
    m_act = m_sh;
    m_pend = 1'b0; m_in_pkt = 1'b0; m_done = 1'b0; m_gen = 0;
    sb_q.delete();
  endtask

  task automatic check_state();
    chk("pending", cfg_pending, m_pend);
    chk("wr_ready", cfg_wr_ready, !m_pend);
    chk("done", cfg_done, m_done);
    chk("generation", cfg_generation, m_gen[7:0]);
    chk("active_etype", expected_etype, m_act.et);
    for (int i = 0; i < N; i++)
      chk($sformatf("active_entry%0d", i), {has_cus_tag[i], custom_tags[i], custom_tag_masks[i]},
          {m_act.has[i], m_act.tag[i], m_act.mask[i]});
  endtask

  // One clock of stimulus; the model predicts the state that the next edge must produce.
  task automatic step(input logic wv, input logic [3:0] id, input logic has, input logic [T-1:0] tag,
                      input logic [T-1:0] mask, input logic ew, input logic [15:0] ed,
                      input logic cm, input logic tv, input logic tr, input logic tl);
    logic beat, nxt_in;
    snap_t s;
    cfg_wr_valid = wv; cfg_wr_id = id; cfg_wr_has_tag = has; cfg_wr_tag = tag; cfg_wr_mask = mask;
    cfg_etype_wr = ew; cfg_etype_data = ed; cfg_commit = cm;
    mon_tvalid = tv; mon_tready = tr; mon_tlast = tl;
    beat = tv & tr;
    nxt_in = m_in_pkt ? !(beat & tl) : (beat & !tl);
    m_done = 1'b0;
    if (!m_pend) begin
      if (wv) begin
        m_sh.has[id] = has; m_sh.tag[id] = tag; m_sh.mask[id] = mask;
      end
      if (ew) m_sh.et = ed;
      if (cm) begin
        m_pend = 1'b1;
        s = m_sh;
        s.gen = 8'((m_gen + 1) % 256);
        sb_q.push_back(s);
      end
    end else if (!nxt_in) begin
      m_act = m_sh;
      m_gen = (m_gen + 1) % 256;
      m_done = 1'b1;
      m_pend = 1'b0;
    end
    m_in_pkt = nxt_in;
    @(posedge aclk);
    @(negedge aclk);
    check_state();
  endtask

  task automatic idle(input logic tv, input logic tr, input logic tl, input logic cm);
    step(1'b0, 4'd0, 1'b0, '0, '0, 1'b0, 16'h0000, cm, tv, tr, tl);
  endtask

  task automatic rand_step(input int p_v, input int p_l);
    logic [63:0] r1, r2;
    r1 = {$urandom, $urandom};
    r2 = {$urandom, $urandom};
    step(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), 1'($urandom), r1[T-1:0], r2[T-1:0],
         ($urandom_range(0, 4) == 0), 16'($urandom), ($urandom_range(0, 5) == 0),
         ($urandom_range(0, 99) < p_v), ($urandom_range(0, 99) < p_v), ($urandom_range(0, 99) < p_l));
  endtask

  // Monitor: every done pulse must match the oldest outstanding commit snapshot.
  initial begin
    snap_t e;
    forever begin
      @(negedge aclk);
      if (aresetn && cfg_done) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected_done: got done=1 expected no outstanding commit");
        end else begin
          e = sb_q.pop_front();
          chk("sb_generation", cfg_generation, e.gen);
          chk("sb_etype", expected_etype, e.et);
          for (int i = 0; i < N; i++)
            chk($sformatf("sb_entry%0d", i), {has_cus_tag[i], custom_tags[i], custom_tag_masks[i]},
                {e.has[i], e.tag[i], e.mask[i]});
        end
      end
    end
  end

  initial begin
    model_reset();
    #12;
    check_state();
    chk("reset_etype", expected_etype, RST_ET);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);

    // Idle stream: write + etype + commit in one cycle, applied on the following edge.
    step(1'b1, 4'd3, 1'b1, 48'h0000_1234_5678, {T{1'b1}}, 1'b1, 16'h88B5, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_tag3", custom_tags[3], 48'h0000_1234_5678);
    chk("t2_etype", expected_etype, 16'h88B5);
    chk("t2_gen", cfg_generation, 8'd1);
    idle(1'b0, 1'b0, 1'b0, 1'b0);

    // Commit on first beat of a 3-beat packet; apply at the tlast edge.
    step(1'b1, 4'd5, 1'b1, 48'hAAAA_BBBB_CCCC, 48'hFFFF_0000_FFFF, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t3_tag5", custom_tags[5], 48'hAAAA_BBBB_CCCC);

    // Back-to-back single-beat packets: every commit applies on the next edge.
    for (int k = 0; k < 3; k++) begin
      idle(1'b1, 1'b1, 1'b1, 1'b1);
      idle(1'b1, 1'b1, 1'b1, 1'b0);
    end
    chk("t4_gen", cfg_generation, 8'd5);

    // Pending mid-packet: writes rejected, second commit absorbed.
    idle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 4'd7, 1'b1, 48'h1111_2222_3333, 48'h1, 1'b1, 16'h9999, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b1, 1'b1, 1'b1, 1'b0);
    idle(1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_tag7", custom_tags[7], 48'h0);

    // Reset while pending mid-packet.
    idle(1'b1, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    aresetn = 1'b0;
    #1;
    model_reset();
    check_state();
    @(negedge aclk);
    aresetn = 1'b1;
    idle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_gen_after_reset", cfg_generation, 8'd1);

    // Randomized traffic across differing stream densities.
    for (int ph = 0; ph < 4; ph++)
      for (int c = 0; c < 400; c++)
        rand_step(30 + ph * 20, 10 + ph * 25);

    // Generation wrap: keep committing until the counter passes 255.
    for (int k = 0; k < 260; k++) begin
      idle(1'b1, 1'b1, 1'b1, 1'b1);
      idle(1'b1, 1'b1, 1'b1, 1'b0);
      if (m_gen == 0) chk("t7_wrap", cfg_generation, 8'd0);
    end

    for (int k = 0; k < 4; k++) idle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("sb_drained", 128'(sb_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
